// File: rtl/multistep_align_shifter.sv
// Multi-cycle mantissa shifter: right align with guard/round/sticky capture,
// left shift, and normalise-to-leading-one, up to STEP positions per cycle.
module multistep_align_shifter #(
    parameter int WIDTH = 24,
    parameter int CNT_W = 8,
    parameter int STEP  = 1
) (
    input  logic             Clk,
    input  logic             Clear,
    input  logic             Start,
    input  logic [WIDTH-1:0] Data,
    input  logic [CNT_W-1:0] Count,
    input  logic [1:0]       Mode,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Result,
    output logic             Guard,
    output logic             Round,
    output logic             Sticky,
    output logic [CNT_W-1:0] Shift_amt,
    output logic             Zero
);

    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
    typedef enum logic [1:0] {M_RIGHT = 2'b00, M_LEFT = 2'b01, M_NORM = 2'b10} mode_t;

    state_t           state_q, state_d;
    mode_t            mode_q, start_mode;
    logic [WIDTH-1:0] a_q, a_d;
    logic             g_q, r_q, s_q, g_d, r_d, s_d;
    logic [CNT_W-1:0] rem_q, amt_q, k;
    logic             zero_q, fin;
    logic             accept, big_r, big_l, fast_hit;

    assign accept    = (state_q == IDLE) && Start;
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);
    assign Result    = a_q;
    assign Guard     = g_q;
    assign Round     = r_q;
    assign Sticky    = s_q;
    assign Shift_amt = amt_q;
    assign Zero      = zero_q;

    // Request decode and fast-path detection on the accepting cycle
    always_comb begin
        start_mode = M_RIGHT;
        case (Mode)
            2'b01:   start_mode = M_LEFT;
            2'b10:   start_mode = M_NORM;
            default: start_mode = M_RIGHT;
        endcase
        big_r    = (start_mode == M_RIGHT) && (int'(Count) >= WIDTH + 2);
        big_l    = (start_mode == M_LEFT)  && (int'(Count) >= WIDTH);
        fast_hit = (Count == '0) || big_r || big_l
                || ((start_mode == M_NORM) && ((Data == '0) || Data[WIDTH-1]));
    end

    // One SHIFT cycle: k = min(STEP, remaining[, leading zeros])
    always_comb begin
        int lz;
        int k_i;
        lz = WIDTH;
        for (int i = 0; i < WIDTH; i++)
            if (a_q[i]) lz = WIDTH - 1 - i;
        k_i = (int'(rem_q) < STEP) ? int'(rem_q) : STEP;
        if ((mode_q == M_NORM) && (lz < k_i)) k_i = lz;
        k = CNT_W'(k_i);

        a_d = a_q;
        g_d = g_q;
        r_d = r_q;
        s_d = s_q;
        case (mode_q)
            M_RIGHT: begin
                // k chained 1-bit steps keep G/R/S exact for any STEP
                for (int i = 0; i < STEP; i++) begin
                    if (i < k_i) begin
                        s_d = s_d | r_d;
                        r_d = g_d;
                        g_d = a_d[0];
                        a_d = a_d >> 1;
                    end
                end
            end
            default: a_d = a_q << k;
        endcase
        fin = (rem_q == k) || ((mode_q == M_NORM) && a_d[WIDTH-1]);
    end

    always_ff @(posedge Clk) begin
        if (Clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Start) state_d = fast_hit ? DONE : SHIFT;
            SHIFT:   if (fin) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Clear) begin
            mode_q <= M_RIGHT;
            a_q    <= '0;
            g_q    <= 1'b0;
            r_q    <= 1'b0;
            s_q    <= 1'b0;
            rem_q  <= '0;
            amt_q  <= '0;
            zero_q <= 1'b0;
        end else if (accept) begin
            mode_q <= start_mode;
            a_q    <= (big_r || big_l) ? '0 : Data;
            g_q    <= 1'b0;
            r_q    <= 1'b0;
            s_q    <= big_r ? (|Data) : 1'b0;
            rem_q  <= Count;
            amt_q  <= (start_mode == M_NORM) ? '0 : Count;
            zero_q <= (start_mode == M_NORM) && (Data == '0);
        end else if (state_q == SHIFT) begin
            a_q   <= a_d;
            g_q   <= g_d;
            r_q   <= r_d;
            s_q   <= s_d;
            rem_q <= rem_q - k;
            if (mode_q == M_NORM) amt_q <= amt_q + k;
        end
    end

endmodule

// File: tb/tb_multistep_align_shifter.sv
// Scoreboard bench: two shifters (STEP=1 and STEP=4) share stimulus; a
// monitor compares each Done against a wide-arithmetic reference model.
module tb_multistep_align_shifter;

    localparam int W  = 24;
    localparam int CW = 8;

    typedef struct {
        logic [W-1:0]  res;
        logic          g, r, s;
        logic [CW-1:0] amt;
        logic          zero;
        int            acc;
        int            done_cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                clear, start;
    logic [W-1:0]        data;
    logic [CW-1:0]       count;
    logic [1:0]          mode;
    logic [1:0]          busy, done, guard, rnd, sticky, zero;
    logic [1:0][W-1:0]   result;
    logic [1:0][CW-1:0]  amt;

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[2][$];
    exp_t hold[2];

    multistep_align_shifter #(.WIDTH(W), .CNT_W(CW), .STEP(1)) u_s1 (
        .Clk(clk), .Clear(clear), .Start(start), .Data(data), .Count(count), .Mode(mode),
        .Busy(busy[0]), .Done(done[0]), .Result(result[0]), .Guard(guard[0]), .Round(rnd[0]),
        .Sticky(sticky[0]), .Shift_amt(amt[0]), .Zero(zero[0]));

    multistep_align_shifter #(.WIDTH(W), .CNT_W(CW), .STEP(4)) u_s4 (
        .Clk(clk), .Clear(clear), .Start(start), .Data(data), .Count(count), .Mode(mode),
        .Busy(busy[1]), .Done(done[1]), .Result(result[1]), .Guard(guard[1]), .Round(rnd[1]),
        .Sticky(sticky[1]), .Shift_amt(amt[1]), .Zero(zero[1]));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic exp_t zero_exp();
        exp_t e;
        e.res = '0; e.g = 1'b0; e.r = 1'b0; e.s = 1'b0;
        e.amt = '0; e.zero = 1'b0; e.acc = 0; e.done_cyc = 0;
        return e;
    endfunction

    function automatic logic [63:0] pack_e(input exp_t e);
        return 64'({e.res, e.g, e.r, e.s, e.amt, e.zero});
    endfunction

    function automatic logic [63:0] pack_d(input int d);
        return 64'({result[d], guard[d], rnd[d], sticky[d], amt[d], zero[d]});
    endfunction

    // Reference: shift into a wide fraction field, then read off G/R/S
    function automatic exp_t model(input logic [W-1:0] d, input logic [CW-1:0] c,
                                   input logic [1:0] m, input int stp, input int acc);
        exp_t           e;
        logic [W+255:0] v;
        int             ci, lz, n, lat;
        e   = zero_exp();
        ci  = int'(c);
        lat = 1;
        case (m)
            2'b01: begin
                e.res = d << ci;
                e.amt = c;
                if (ci != 0 && ci < W) lat = (ci + stp - 1) / stp + 1;
            end
            2'b10: begin
                if (d == '0) e.zero = 1'b1;
                else begin
                    lz = W;
                    for (int i = 0; i < W; i++) if (d[i]) lz = W - 1 - i;
                    n = (lz < ci) ? lz : ci;
                    e.res = d << n;
                    e.amt = CW'(n);
                    if (n != 0) lat = (n + stp - 1) / stp + 1;
                end
            end
            default: begin
                v     = {d, 256'b0} >> ci;
                e.res = v[W+255:256];
                e.g   = v[255];
                e.r   = v[254];
                e.s   = |v[253:0];
                e.amt = c;
                if (ci != 0 && ci < W + 2) lat = (ci + stp - 1) / stp + 1;
            end
        endcase
        e.acc      = acc;
        e.done_cyc = acc + lat;
        return e;
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (sbq[d].size() > 0) begin
                e = sbq[d][0];
                if (done[d]) begin
                    chk($sformatf("latency%0d", d), 64'(cyc), 64'(e.done_cyc));
                    chk($sformatf("busy_at_done%0d", d), 64'(busy[d]), 64'd1);
                    chk($sformatf("outputs%0d", d), pack_d(d), pack_e(e));
                    hold[d] = e;
                    void'(sbq[d].pop_front());
                end else if (cyc >= e.done_cyc) begin
                    chk($sformatf("done_missing%0d", d), 64'(done[d]), 64'd1);
                    hold[d] = e;
                    void'(sbq[d].pop_front());
                end else if (cyc > e.acc) begin
                    chk($sformatf("busy%0d", d), 64'(busy[d]), 64'd1);
                end
            end else begin
                if (done[d]) chk($sformatf("unexpected_done%0d", d), 64'(done[d]), 64'd0);
                if (!busy[d]) chk($sformatf("hold%0d", d), pack_d(d), pack_e(hold[d]));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] d, input logic [CW-1:0] c, input logic [1:0] m);
        int t;
        t = 0;
        while (busy != 2'b00 && t < 400) begin
            tick();
            t++;
        end
        if (busy != 2'b00) begin
            chk("idle_wait", 64'(busy), 64'd0);
            return;
        end
        data  = d;
        count = c;
        mode  = m;
        start = 1'b1;
        sbq[0].push_back(model(d, c, m, 1, cyc));
        sbq[1].push_back(model(d, c, m, 4, cyc));
        tick();
        start = 1'b0;
    endtask

    task automatic check_cleared(input string nm);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("%s_busy%0d", nm, d), 64'({busy[d], done[d]}), 64'd0);
            chk($sformatf("%s_out%0d", nm, d), pack_d(d), 64'd0);
        end
    endtask

    initial begin
        logic [W-1:0]  rd;
        logic [CW-1:0] rc;
        int            t;

        hold[0] = zero_exp();
        hold[1] = zero_exp();
        clear = 1'b1; start = 1'b1; data = 24'h800001; count = 8'd3; mode = 2'b00;
        tick();
        tick();
        check_cleared("reset");
        start = 1'b0;
        clear = 1'b0;
        tick();

        issue(24'h800001, 8'd3,  2'b00);
        issue(24'h000005, 8'd30, 2'b00);
        issue(24'hC00001, 8'd24, 2'b00);
        issue(24'h800001, 8'd25, 2'b11);
        issue(24'h000F00, 8'd31, 2'b10);
        issue(24'h000F00, 8'd5,  2'b10);
        issue(24'h000000, 8'd9,  2'b10);
        issue(24'h812345, 8'd9,  2'b10);
        issue(24'hFFFFFF, 8'd24, 2'b01);
        issue(24'hFFFFFF, 8'd0,  2'b01);

        // Start pulsed while busy must be ignored
        issue(24'h000001, 8'd10, 2'b01);
        tick();
        data = 24'hABCDEF; count = 8'd3; mode = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;

        // Clear mid-operation aborts with no Done
        issue(24'h123456, 8'd20, 2'b00);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        hold[0] = zero_exp();
        hold[1] = zero_exp();
        check_cleared("abort");

        // Clear together with Start stays idle
        clear = 1'b1; start = 1'b1; data = 24'h00FF00; count = 8'd2; mode = 2'b01;
        tick();
        clear = 1'b0; start = 1'b0;
        check_cleared("clr_start");
        tick();
        check_cleared("clr_start_next");

        issue(24'h800001, 8'd3, 2'b00);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 5))
                0:       rd = '0;
                1:       rd = W'($urandom) | 24'h800000;
                2:       rd = W'($urandom) >> $urandom_range(0, 23);
                default: rd = W'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       rc = CW'($urandom_range(0, 255));
                1:       rc = CW'(W - 1 + $urandom_range(0, 3));
                default: rc = CW'($urandom_range(0, 30));
            endcase
            issue(rd, rc, 2'($urandom_range(0, 3)));
        end

        t = 0;
        while ((sbq[0].size() > 0 || sbq[1].size() > 0) && t < 400) begin
            tick();
            t++;
        end
        chk("drain", 64'(sbq[0].size() + sbq[1].size()), 64'd0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
